imem_load_controller: RTL

//  Sequences program download into InstructionMemory for the TP4 pipeline.
//  - Assembles 8-bit debug-unit bytes into 32-bit words.
//  - Drives the write port sequentially from address 0.
//  - Holds the CPU during download and releases it after the HALT word.
//  - After release, passes the pipeline PC to the memory address port.

---
 rtl/imem_load_controller_pkg.sv | 22 ++
 rtl/imem_load_controller_byte_assembler.sv | 39 +++
 rtl/imem_load_controller.sv | 127 ++++++++++++
 3 files changed

// File: rtl/imem_load_controller_pkg.sv
// ============================================================================
// imem_load_controller_pkg : shared defaults and FSM state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package imem_load_controller_pkg;

  localparam int unsigned DEPTH_DEF     = 32;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/imem_load_controller_byte_assembler.sv
// ============================================================================
// imem_load_controller_byte_assembler : 8->32 MSB-first byte packer
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_load_controller_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shreg_q;
  logic [1:0]  byte_cnt_q;

  // The 4th byte completes the word combinationally so the top can latch it
  // on the same edge; the counter wraps back to 0 at that point.
  assign word_valid = in_valid && !clr && (byte_cnt_q == 2'd3);
  assign word       = {shreg_q, in_byte};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q    <= '0;
      byte_cnt_q <= '0;
    end else if (clr) begin
      byte_cnt_q <= '0;
    end else if (in_valid) begin
      shreg_q    <= {shreg_q[15:0], in_byte};
      byte_cnt_q <= byte_cnt_q + 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_load_controller.sv
// ============================================================================
// imem_load_controller : download sequencer for instruction memory
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_load_controller
  import imem_load_controller_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [31:0]       pc_addr,
  output logic [31:0]       imem_addr,
  output logic              imem_wr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   word_addr_q, word_addr_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                w_accept;
  logic                w_word_valid;
  logic [31:0]         w_word;

  // Bytes are taken in WRITE too, so a back-to-back stream never loses one.
  assign w_accept = rx_valid && !load_start &&
                    ((state_q == ST_COLLECT) || (state_q == ST_WRITE));

  imem_load_controller_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (load_start),
    .in_valid   (w_accept),
    .in_byte    (rx_data),
    .word_valid (w_word_valid),
    .word       (w_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      word_addr_q  <= '0;
      word_count_q <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      word_addr_q  <= word_addr_d;
      word_count_q <= word_count_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_addr_d  = word_addr_q;
    word_count_d = word_count_q;
    wdata_d      = wdata_q;

    if (w_word_valid) begin
      wdata_d = w_word;
    end

    case (state_q)
      ST_IDLE: begin
        if (load_start) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (w_word_valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        word_count_d = word_count_q + (ADDR_W+1)'(1);
        if (wdata_q == HALT_WORD) begin
          state_d = ST_DONE;
        end else if (word_addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_ERROR;
        end else begin
          word_addr_d = word_addr_q + ADDR_W'(1);
          state_d     = ST_COLLECT;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (load_start) state_d = ST_COLLECT;
      end
      default: state_d = ST_IDLE;
    endcase

    // A restart overrides everything; a write already on the port this cycle
    // still completes because imem_wr is decoded from the current state.
    if (load_start) begin
      state_d      = ST_COLLECT;
      word_addr_d  = '0;
      word_count_d = '0;
    end
  end

  always_comb begin
    imem_addr = '0;
    if (state_q == ST_WRITE) begin
      imem_addr = {{(32-ADDR_W){1'b0}}, word_addr_q};
    end else if (state_q == ST_DONE) begin
      imem_addr = pc_addr;
    end
  end

  assign imem_wr    = (state_q == ST_WRITE);
  assign imem_wdata = wdata_q;
  assign cpu_hold   = (state_q != ST_DONE);
  assign load_done  = (state_q == ST_DONE);
  assign load_err   = (state_q == ST_ERROR);
  assign word_count = word_count_q;

endmodule

`default_nettype wire
